// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target endpoint and its bus synchronizer.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        T_IDLE,
        T_ADDR,
        T_ADDR_ACK,
        T_RX_DATA,
        T_RX_ACK,
        T_TX_DATA,
        T_TX_ACK,
        T_IGNORE
    } e_target_states;

    localparam logic [6:0] GCALL_ADDR = 7'h00;
    localparam logic       ACK        = 1'b0;
    localparam logic       NACK       = 1'b1;

    // General call is write-only; a general-call read is never claimed.
    function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] own,
                                        input logic rw, input logic gcall_en);
        return (addr == own) || (gcall_en && (addr == GCALL_ADDR) && (rw == 1'b0));
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA and emits registered START/STOP/rise/fall pulses plus the
// SDA level aligned with those pulses. Reusable by a controller for bus monitoring.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic start,
    output logic stop,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_ff[SYNC_STAGES-1];
    assign sda_s = sda_ff[SYNC_STAGES-1];
    assign sda   = sda_q;

    // Flops reset to the idle-bus level so leaving reset creates no phantom edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
            start  <= 1'b0;
            stop   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
            scl_q  <= scl_s;
            sda_q  <= sda_s;
            start  <= scl_s & scl_q & sda_q & ~sda_s;
            stop   <= scl_s & scl_q & ~sda_q & sda_s;
            rise   <= scl_s & ~scl_q;
            fall   <= ~scl_s & scl_q;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match/ACK, byte receive to fabric, byte transmit from fabric.
// Define I2C_TARGET_GCALL_EN to also accept general-call (8'h00) writes.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

`ifdef I2C_TARGET_GCALL_EN
    localparam logic GCALL_ON = 1'b1;
`else
    localparam logic GCALL_ON = 1'b0;
`endif

    e_target_states state;
    logic [2:0]     cnt;
    logic           slot;
    logic           rw;
    logic [7:0]     shift;
    logic           sda;
    logic           start;
    logic           stop;
    logic           rise;
    logic           fall;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .scl_i (scl_i),
        .sda_i (sda_i),
        .sda   (sda),
        .start (start),
        .stop  (stop),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= T_IDLE;
            cnt      <= 3'd0;
            slot     <= 1'b0;
            rw       <= 1'b0;
            shift    <= 8'h00;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start) begin
                state  <= T_ADDR;
                cnt    <= 3'd0;
                slot   <= 1'b0;
                sda_oe <= 1'b0;
            end else if (stop) begin
                state  <= T_IDLE;
                cnt    <= 3'd0;
                slot   <= 1'b0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    T_ADDR: begin
                        if (rise) begin
                            shift <= {shift[6:0], sda};
                            if (cnt == 3'd7) begin
                                cnt  <= 3'd0;
                                slot <= 1'b0;
                                rw   <= sda;
                                if (addr_match(shift[6:0], ADDR, sda, GCALL_ON)) begin
                                    state <= T_ADDR_ACK;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= T_IGNORE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    // slot=0: next fall pulls SDA; rise marks the ACK clock; slot=1 fall leaves.
                    T_ADDR_ACK, T_RX_ACK: begin
                        if (fall) begin
                            if (!slot) begin
                                sda_oe <= 1'b1;
                            end else begin
                                slot <= 1'b0;
                                if (state == T_ADDR_ACK && rw) begin
                                    shift  <= {tx_data[6:0], 1'b0};
                                    tx_req <= 1'b1;
                                    sda_oe <= ~tx_data[7];
                                    state  <= T_TX_DATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= T_RX_DATA;
                                end
                            end
                        end else if (rise) begin
                            slot <= 1'b1;
                        end
                    end
                    T_RX_DATA: begin
                        if (rise) begin
                            shift <= {shift[6:0], sda};
                            if (cnt == 3'd7) begin
                                rx_data  <= {shift[6:0], sda};
                                rx_valid <= 1'b1;
                                cnt      <= 3'd0;
                                slot     <= 1'b0;
                                state    <= T_RX_ACK;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    // Bit 7 is already on the bus; falls 1..7 drive bits 6..0, fall 8 releases.
                    T_TX_DATA: begin
                        if (fall) begin
                            if (cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                cnt    <= 3'd0;
                                slot   <= 1'b0;
                                state  <= T_TX_ACK;
                            end else begin
                                sda_oe <= ~shift[7];
                                shift  <= {shift[6:0], 1'b0};
                                cnt    <= cnt + 3'd1;
                            end
                        end
                    end
                    T_TX_ACK: begin
                        if (rise && !slot) begin
                            if (sda == NACK) begin
                                sda_oe <= 1'b0;
                                state  <= T_IGNORE;
                            end else begin
                                slot <= 1'b1;
                            end
                        end else if (fall && slot) begin
                            slot   <= 1'b0;
                            shift  <= {tx_data[6:0], 1'b0};
                            tx_req <= 1'b1;
                            sda_oe <= ~tx_data[7];
                            state  <= T_TX_DATA;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: table of write transfers plus read, repeated-START
// and reset-mid-byte sequences driven through a wired-AND SDA model.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int T_Q = 60;

`ifdef I2C_TARGET_GCALL_EN
    localparam logic GC = 1'b1;
`else
    localparam logic GC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target #(
        .ADDR        (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rd_idx = 0;
    int         tx_req_cnt = 0;
    int         oe_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] tx_list[4];

    // Monitor sampled on the falling clock edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (tx_req) tx_req_cnt = tx_req_cnt + 1;
        if (sda_oe) oe_cnt = oe_cnt + 1;
        if (rx_valid && tx_req) both_cnt = both_cnt + 1;
        tx_data = tx_list[tx_req_cnt & 3];
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack;
    } wr_vec_t;

    wr_vec_t vec[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b;
        #T_Q scl_m = 1'b1;
        #T_Q s = sda_line;
        #T_Q scl_m = 1'b0;
        #T_Q;
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        #T_Q scl_m = 1'b1;
        #T_Q sda_m = 1'b0;
        #T_Q scl_m = 1'b0;
        #T_Q;
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        #T_Q scl_m = 1'b1;
        #T_Q sda_m = 1'b1;
        #(2 * T_Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic master_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(master_bit, s);
    endtask

    task automatic check_rx(input string name);
        logic [7:0] e;
        logic [7:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 8'hxx;
            chk(name, {24'h0, g}, {24'h0, e});
            rd_idx++;
        end
        rd_idx = got_q.size();
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        logic       s;
        int         oe0;
        int         rx0;
        int         tx0;

        tx_list[0] = 8'h96;
        tx_list[1] = 8'h5A;
        tx_list[2] = 8'hC5;
        tx_list[3] = 8'h33;
        vec[0] = '{addr: 8'hA0, d0: 8'h3C, d1: 8'h81, ack: 1'b1};
        vec[1] = '{addr: 8'hA2, d0: 8'h55, d1: 8'hAA, ack: 1'b0};
        vec[2] = '{addr: 8'hA0, d0: 8'h00, d1: 8'hFF, ack: 1'b1};
        vec[3] = '{addr: 8'h00, d0: 8'hC3, d1: 8'h7E, ack: GC};
        vec[4] = '{addr: 8'hA4, d0: 8'h12, d1: 8'h34, ack: 1'b0};

        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        #22;
        chk("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
        chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_tx_req", {31'h0, tx_req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        #100;

        for (int v = 0; v < 5; v++) begin
            oe0 = oe_cnt;
            rx0 = got_q.size();
            do_start();
            write_byte(vec[v].addr, a);
            chk("addr_ack", {31'h0, a}, {31'h0, vec[v].ack});
            chk("busy_mid", {31'h0, busy}, {31'h0, vec[v].ack});
            write_byte(vec[v].d0, a);
            chk("d0_ack", {31'h0, a}, {31'h0, vec[v].ack});
            write_byte(vec[v].d1, a);
            chk("d1_ack", {31'h0, a}, {31'h0, vec[v].ack});
            do_stop();
            chk("busy_after_stop", {31'h0, busy}, 32'h0);
            chk("rx_count", got_q.size() - rx0, vec[v].ack ? 32'd2 : 32'd0);
            if (vec[v].ack) begin
                exp_q.push_back(vec[v].d0);
                exp_q.push_back(vec[v].d1);
            end else begin
                chk("oe_quiet", oe_cnt - oe0, 32'd0);
            end
            check_rx("rx_data");
        end

        // Read: master ACKs the first byte and NACKs the second.
        tx0 = tx_req_cnt;
        do_start();
        write_byte(8'hA1, a);
        chk("rd_addr_ack", {31'h0, a}, 32'h1);
        chk("rd_busy", {31'h0, busy}, 32'h1);
        read_byte(1'b0, d);
        chk("rd_byte0", {24'h0, d}, 32'h96);
        read_byte(1'b1, d);
        chk("rd_byte1", {24'h0, d}, 32'h5A);
        chk("rd_oe_after_nack", {31'h0, sda_oe}, 32'h0);
        oe0 = oe_cnt;
        #(4 * T_Q);
        chk("rd_oe_quiet", oe_cnt - oe0, 32'd0);
        do_stop();
        chk("rd_tx_req_cnt", tx_req_cnt - tx0, 32'd2);
        chk("rd_busy_stop", {31'h0, busy}, 32'h0);

        // Repeated START: write one byte, then re-address for a read with no STOP.
        rx0 = got_q.size();
        do_start();
        write_byte(8'hA0, a);
        chk("sr_addr_ack", {31'h0, a}, 32'h1);
        write_byte(8'h11, a);
        chk("sr_d_ack", {31'h0, a}, 32'h1);
        do_start();
        chk("sr_busy_after_sr", {31'h0, busy}, 32'h1);
        write_byte(8'hA1, a);
        chk("sr_rd_addr_ack", {31'h0, a}, 32'h1);
        chk("sr_busy_rd", {31'h0, busy}, 32'h1);
        chk("sr_rx_count", got_q.size() - rx0, 32'd1);
        exp_q.push_back(8'h11);
        check_rx("sr_rx_data");
        read_byte(1'b1, d);
        chk("sr_rd_byte", {24'h0, d}, 32'hC5);
        do_stop();
        chk("sr_busy_stop", {31'h0, busy}, 32'h0);

        // Reset after four data bits, then a clean transaction.
        do_start();
        write_byte(8'hA0, a);
        chk("rm_addr_ack", {31'h0, a}, 32'h1);
        for (int i = 0; i < 4; i++) bus_bit(1'b0, s);
        #4;
        chk("rm_busy_pre", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rm_sda_oe", {31'h0, sda_oe}, 32'h0);
        chk("rm_busy", {31'h0, busy}, 32'h0);
        chk("rm_rx_data", {24'h0, rx_data}, 32'h0);
        chk("rm_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("rm_tx_req", {31'h0, tx_req}, 32'h0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        #50 rst = 1'b0;
        #100;
        rx0 = got_q.size();
        rd_idx = got_q.size();
        do_start();
        write_byte(8'hA0, a);
        chk("post_addr_ack", {31'h0, a}, 32'h1);
        write_byte(8'h3C, a);
        chk("post_d_ack", {31'h0, a}, 32'h1);
        do_stop();
        chk("post_rx_count", got_q.size() - rx0, 32'd1);
        exp_q.push_back(8'h3C);
        check_rx("post_rx_data");
        chk("post_busy", {31'h0, busy}, 32'h0);

        chk("no_overlap", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
